// File: rtl/pet_prg_dump.sv
// pet_prg_dump: reads the BASIC program from PET RAM over DMA and streams it as a .PRG image
module pet_prg_dump #(
  parameter logic [15:0] PTR_START = 16'h0028,
  parameter logic [15:0] PTR_END   = 16'h002A,
  parameter logic [15:0] MAX_LEN   = 16'h8000
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [14:0] dma_addr,
  output logic        dma_rd,
  input  logic [7:0]  dma_dout,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [16:0] out_addr,
  output logic        out_last
);
  typedef enum logic [2:0] {IDLE, PTR, CHECK, HDR0, HDR1, BODY, DONE} state_t;
  state_t state;
  logic [31:0] ptrs;
  logic [15:0] ra, oi, st, en, len;
  logic rd_q, buf_v, fire, ofree, bad, iss;
  logic [7:0] buf_d;
  always_comb begin
    st = ptrs[15:0];
    en = ptrs[31:16];
    len = en - st;
    fire = out_valid & out_ready;
    ofree = !out_valid | out_ready;
    bad = en <= st || len > MAX_LEN || en > 16'h8000;
    // a body read is only issued when the output register plus one prefetch slot can absorb it
    iss = !dma_rd && (state == PTR ? ra < 16'd4 :
          state == BODY && ra < len && 2'(out_valid & !out_ready) + 2'(buf_v) + 2'(rd_q) <= 2'd1);
  end
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
      dma_rd <= 1'b0;
      dma_addr <= '0;
      out_valid <= 1'b0;
      out_last <= 1'b0;
      out_addr <= '0;
      out_data <= '0;
      ptrs <= '0;
      ra <= '0;
      oi <= '0;
      rd_q <= 1'b0;
      buf_v <= 1'b0;
      buf_d <= '0;
    end else begin
      rd_q <= dma_rd;
      dma_rd <= iss;
      if (iss) begin
        dma_addr <= state == PTR ? 15'((ra[1] ? PTR_END : PTR_START) + 16'(ra[0])) : 15'(st + ra);
        ra <= ra + 16'd1;
      end
      case (state)
        IDLE: if (start) begin
          state <= PTR;
          busy <= 1'b1;
          err <= 1'b0;
          ra <= '0;
          oi <= '0;
        end
        PTR: if (rd_q) begin
          ptrs <= {dma_dout, ptrs[31:8]};
          oi <= oi + 16'd1;
          if (oi == 16'd3) state <= CHECK;
        end
        CHECK: begin
          oi <= '0;
          ra <= '0;
          if (bad) begin
            state <= DONE;
            done <= 1'b1;
            err <= 1'b1;
          end else begin
            state <= HDR0;
            out_valid <= 1'b1;
            out_data <= st[7:0];
            out_addr <= '0;
          end
        end
        HDR0: if (fire) begin
          state <= HDR1;
          out_data <= st[15:8];
          out_addr <= 17'd1;
        end
        HDR1: if (fire) begin
          state <= BODY;
          out_valid <= 1'b0;
        end
        BODY: begin
          buf_v <= ofree ? buf_v & rd_q : buf_v | rd_q;
          if (rd_q && (buf_v || !ofree)) buf_d <= dma_dout;
          if (ofree && (buf_v || rd_q)) begin
            out_valid <= 1'b1;
            out_data <= buf_v ? buf_d : dma_dout;
            out_addr <= 17'(oi) + 17'd2;
            out_last <= oi == len - 16'd1;
            oi <= oi + 16'd1;
          end else if (fire) out_valid <= 1'b0;
          if (fire && out_last) begin
            state <= DONE;
            done <= 1'b1;
            out_valid <= 1'b0;
            out_last <= 1'b0;
          end
        end
        DONE: begin
          state <= IDLE;
          done <= 1'b0;
          err <= 1'b0;
          busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pet_prg_dump.sv
// tb_pet_prg_dump: scoreboard bench for the PRG dump engine against a registered RAM model
module tb_pet_prg_dump;
  logic clk_sys = 1'b0, reset_n = 1'b0, start = 1'b0, out_ready = 1'b1;
  logic busy, done, err, dma_rd, out_valid, out_last;
  logic [14:0] dma_addr;
  logic [7:0] dma_dout = 8'h00, out_data;
  logic [16:0] out_addr;
  logic [7:0] ram [0:32767];
  logic [25:0] q [$];
  logic [7:0] c1 [0:6] = '{8'h01, 8'h04, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
  int total = 0, bad = 0, done_cnt = 0, valid_cnt = 0, rd_cnt = 0;
  bit rmode = 1'b0, held = 1'b0, last_err = 1'b0;
  logic [16:0] h_addr;
  logic [7:0] h_data;
  logic [25:0] e;

  pet_prg_dump dut (.clk_sys(clk_sys), .reset_n(reset_n), .start(start), .busy(busy), .done(done),
    .err(err), .dma_addr(dma_addr), .dma_rd(dma_rd), .dma_dout(dma_dout), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr), .out_last(out_last));

  always #5 clk_sys = ~clk_sys;

  always @(posedge clk_sys) begin
    if (dma_rd) begin
      dma_dout <= ram[dma_addr];
      rd_cnt++;
    end
  end

  always @(posedge clk_sys) begin
    #1;
    out_ready = rmode ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  always @(negedge clk_sys) begin
    if (!reset_n) held = 1'b0;
    else begin
      if (held) chk("stall_hold", {13'd0, out_valid, out_addr, out_data}, {13'd0, 1'b1, h_addr, h_data});
      held = out_valid && !out_ready;
      h_addr = out_addr;
      h_data = out_data;
      if (done) begin
        done_cnt++;
        last_err = err;
      end
      if (out_valid) valid_cnt++;
      if (out_valid && out_ready) begin
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL extra_byte: got %h at %h want none", out_data, out_addr);
        end else begin
          e = q.pop_front();
          total--;
          chk("byte", {6'd0, out_last, out_addr, out_data}, {6'd0, e});
        end
      end
    end
  end

  task automatic push(input logic [7:0] d, input logic [16:0] a, input logic l);
    q.push_back({l, a, d});
  endtask

  task automatic setup1();
    ram[16'h28] = 8'h01; ram[16'h29] = 8'h04; ram[16'h2A] = 8'h06; ram[16'h2B] = 8'h04;
    ram[16'h401] = 8'hAA; ram[16'h402] = 8'hBB; ram[16'h403] = 8'hCC;
    ram[16'h404] = 8'hDD; ram[16'h405] = 8'hEE;
  endtask

  task automatic push1();
    for (int i = 0; i < 7; i++) push(c1[i], 17'(i), i == 6);
  endtask

  task automatic dump(input bit exp_err, input bit spam, input string nm);
    bit got = 1'b0;
    done_cnt = 0; valid_cnt = 0; rd_cnt = 0;
    @(posedge clk_sys); #1 start = 1'b1;
    @(posedge clk_sys); #1 start = 1'b0;
    chk({nm, "_busy_on"}, 32'(busy), 32'd1);
    for (int cyc = 0; cyc < 70000 && !got; cyc++) begin
      @(posedge clk_sys); #1;
      if (done) begin
        got = 1'b1;
        start = spam;
        @(posedge clk_sys); #1 start = 1'b0;
      end else start = spam && (cyc % 3 == 0);
    end
    if (!got) begin
      total++; bad++;
      $display("FAIL %s_timeout: got no done want done", nm);
    end
    repeat (3) @(posedge clk_sys);
    #1;
    chk({nm, "_done_cnt"}, 32'(done_cnt), 32'd1);
    chk({nm, "_err"}, 32'(last_err), 32'(exp_err));
    chk({nm, "_queue_left"}, 32'(q.size()), 32'd0);
    chk({nm, "_busy_off"}, 32'(busy), 32'd0);
  endtask

  initial begin
    bit hit;
    void'($urandom(32'd1234));
    for (int i = 0; i < 32768; i++) ram[i] = 8'(i * 37 + (i >> 7));
    repeat (3) @(posedge clk_sys);
    #1;
    chk("reset_flags", {26'd0, busy, done, err, dma_rd, out_valid, out_last}, 32'd0);
    chk("reset_addr", {dma_addr, out_addr}, 32'd0);
    chk("reset_data", 32'(out_data), 32'd0);
    reset_n = 1'b1;

    setup1(); push1();
    dump(1'b0, 1'b0, "c1");
    chk("c1_rd_cnt", 32'(rd_cnt), 32'd9);

    rmode = 1'b1;
    push1();
    dump(1'b0, 1'b0, "c2");
    rmode = 1'b0;

    ram[16'h2A] = 8'h01;
    dump(1'b1, 1'b0, "c3");
    chk("c3_rd_cnt", 32'(rd_cnt), 32'd4);
    chk("c3_valid_cnt", 32'(valid_cnt), 32'd0);

    ram[16'h2A] = 8'h00; ram[16'h2B] = 8'h90;
    dump(1'b1, 1'b0, "c4a");
    chk("c4a_rd_cnt", 32'(rd_cnt), 32'd4);
    chk("c4a_valid_cnt", 32'(valid_cnt), 32'd0);

    setup1(); push1();
    dump(1'b0, 1'b1, "c6");

    push1();
    done_cnt = 0;
    hit = 1'b0;
    @(posedge clk_sys); #1 start = 1'b1;
    @(posedge clk_sys); #1 start = 1'b0;
    for (int cyc = 0; cyc < 200 && !hit; cyc++) begin
      @(posedge clk_sys); #1;
      hit = out_valid && out_addr == 17'd5;
    end
    chk("c5_reach_byte3", 32'(hit), 32'd1);
    reset_n = 1'b0;
    @(posedge clk_sys); #1;
    chk("c5_rst_flags", {26'd0, busy, done, err, dma_rd, out_valid, out_last}, 32'd0);
    chk("c5_rst_addr", {dma_addr, out_addr}, 32'd0);
    chk("c5_rst_data", 32'(out_data), 32'd0);
    reset_n = 1'b1;
    repeat (5) @(posedge clk_sys);
    #1;
    chk("c5_no_done", 32'(done_cnt), 32'd0);
    q.delete();
    push1();
    dump(1'b0, 1'b0, "c5_rerun");

    ram[16'h28] = 8'h00; ram[16'h29] = 8'h00; ram[16'h2A] = 8'h00; ram[16'h2B] = 8'h80;
    push(8'h00, 17'd0, 1'b0);
    push(8'h00, 17'd1, 1'b0);
    for (int i = 0; i < 32768; i++) push(ram[i], 17'(i + 2), i == 32767);
    dump(1'b0, 1'b0, "c4b");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
